// File: rtl/main_fsm.sv
// main_fsm: multicycle RV32I control sequencer driving the shared datapath selects and strobes.
module main_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
        EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10
    } state_t;
    state_t s;
    logic pc_update, branch;
    always_ff @(posedge clk) begin
        if (rst) s <= FETCH;
        else case (s)
            FETCH:    s <= mem_ready ? DECODE : FETCH;
            DECODE: case (op)
                OP_LW, OP_SW: s <= MEMADR;
                OP_R:         s <= EXECUTER;
                OP_I:         s <= EXECUTEI;
                OP_BEQ:       s <= BEQ;
                OP_JAL:       s <= JAL;
                default:      s <= FETCH;
            endcase
            MEMADR:   s <= (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  s <= mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: s <= mem_ready ? FETCH : MEMWRITE;
            EXECUTER, EXECUTEI, JAL: s <= ALUWB;
            default:  s <= FETCH;
        endcase
    end
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        illegal   = 1'b0;
        if (!rst) case (s)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: RegWrite = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
        PCWrite = pc_update | (branch & zero);
    end
    assign state = rst ? 4'd0 : s;
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized and directed checks of main_fsm against an instruction-plan reference model.
module tb_main_fsm;
    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] op = 7'b0;
    logic PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic [13:0] obs, seen;
    logic [3:0] seen_state;
    int checks = 0, errors = 0;
    int ms = 0;
    int plan[$];
    logic [6:0] ops [8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h7F, 7'h37};

    main_fsm dut (.clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal(illegal), .state(state));

    always #5 clk = ~clk;
    // {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal}
    assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};

    function automatic logic [13:0] expect_out(int s, logic r, logic z, logic [6:0] o, logic rs);
        logic known;
        known = (o == 7'h03) || (o == 7'h23) || (o == 7'h33) || (o == 7'h13) || (o == 7'h63) || (o == 7'h6F);
        if (rs) return 14'b0;
        case (s)
            0:  return {r, 1'b0, r, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
            1:  return {5'b0, 2'b00, 2'b01, 2'b01, 2'b00, !known};
            2:  return {5'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
            3:  return {1'b0, 1'b1, 3'b0, 2'b00, 7'b0};
            4:  return {4'b0, 1'b1, 2'b01, 7'b0};
            5:  return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 7'b0};
            6:  return {5'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
            7:  return {5'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
            8:  return {4'b0, 1'b1, 2'b00, 7'b0};
            9:  return {z, 4'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
            10: return {1'b1, 4'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
            default: return 14'b0;
        endcase
    endfunction

    // One clock: drive, compare against the model, then advance the model's instruction plan.
    task automatic cycle(input logic [6:0] o, input logic z, input logic r, input logic rs, input string tag);
        logic [13:0] e;
        @(negedge clk);
        op = o; zero = z; mem_ready = r; rst = rs;
        #2;
        e = expect_out(ms, r, z, o, rs);
        seen = obs;
        seen_state = state;
        checks++;
        if (state !== (rs ? 4'd0 : 4'(ms))) begin
            errors++;
            $display("FAIL %s state: got %0d want %0d", tag, state, rs ? 0 : ms);
        end
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s outputs (state %0d): got %b want %b", tag, ms, obs, e);
        end
        @(posedge clk);
        if (rs) begin
            ms = 0;
            plan.delete();
        end else if (!((ms == 0 || ms == 3 || ms == 5) && !r)) begin
            if (ms == 1) begin
                plan.delete();
                case (o)
                    7'h03: plan = '{2, 3, 4};
                    7'h23: plan = '{2, 5};
                    7'h33: plan = '{6, 8};
                    7'h13: plan = '{7, 8};
                    7'h63: plan = '{9};
                    7'h6F: plan = '{10, 8};
                    default: ;
                endcase
            end
            if (ms == 0) ms = 1;
            else if (plan.size() > 0) ms = plan.pop_front();
            else ms = 0;
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic z, input int waits, input string tag,
                             output int n, output int pcw, output int regw, output int memw, output int ill);
        int w = 0;
        logic r;
        n = 0; pcw = 0; regw = 0; memw = 0; ill = 0;
        do begin
            r = !(ms == 5 && w < waits);
            if (!r) w++;
            cycle(o, z, r, 1'b0, tag);
            n++;
            pcw += int'(seen[13]);
            regw += int'(seen[9]);
            memw += int'(seen[10]);
            ill += int'(seen[0]);
        end while (ms != 0 && n < 30);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 7; i++) cycle(ops[$urandom_range(0, 7)], 1'($urandom), 1'($urandom), 1'b0, "pre_reset");
        for (int i = 0; i < 2; i++) begin
            cycle(ops[$urandom_range(0, 7)], 1'($urandom), 1'($urandom), 1'b1, "reset");
            checks++;
            if (seen !== 14'b0 || seen_state !== 4'd0) begin
                errors++;
                $display("FAIL reset_zero: got state %0d outs %b want 0", seen_state, seen);
            end
        end
        cycle(7'h33, 1'b0, 1'b1, 1'b0, "release");
        checks++;
        if (seen[11] !== 1'b1 || seen[4:3] !== 2'b10) begin
            errors++;
            $display("FAIL release_fetch: got IRWrite %b ALUSrcB %b want 1 10", seen[11], seen[4:3]);
        end
        for (int i = 0; i < 10 && ms != 0; i++) cycle(7'h33, 1'b0, 1'b1, 1'b0, "drain");
    endtask

    task automatic test_lw();
        int n, pcw, regw, memw, ill;
        run_instr(7'h03, 1'b0, 0, "lw", n, pcw, regw, memw, ill);
        checks++;
        if (n !== 5 || regw !== 1 || memw !== 0) begin
            errors++;
            $display("FAIL lw_latency: got n=%0d regw=%0d memw=%0d want 5 1 0", n, regw, memw);
        end
    endtask

    task automatic test_sw_wait();
        int n, pcw, regw, memw, ill;
        run_instr(7'h23, 1'b0, 3, "sw", n, pcw, regw, memw, ill);
        checks++;
        if (n !== 7 || memw !== 4 || regw !== 0) begin
            errors++;
            $display("FAIL sw_wait: got n=%0d memw=%0d regw=%0d want 7 4 0", n, memw, regw);
        end
    endtask

    task automatic test_beq();
        int n, pcw, regw, memw, ill;
        run_instr(7'h63, 1'b1, 0, "beq_taken", n, pcw, regw, memw, ill);
        checks++;
        if (n !== 3 || pcw !== 2) begin
            errors++;
            $display("FAIL beq_taken: got n=%0d pcw=%0d want 3 2", n, pcw);
        end
        run_instr(7'h63, 1'b0, 0, "beq_not", n, pcw, regw, memw, ill);
        checks++;
        if (n !== 3 || pcw !== 1) begin
            errors++;
            $display("FAIL beq_not_taken: got n=%0d pcw=%0d want 3 1", n, pcw);
        end
    endtask

    task automatic test_r_jal();
        int n, pcw, regw, memw, ill;
        run_instr(7'h33, 1'b0, 0, "rtype", n, pcw, regw, memw, ill);
        checks++;
        if (n !== 4 || regw !== 1) begin
            errors++;
            $display("FAIL rtype: got n=%0d regw=%0d want 4 1", n, regw);
        end
        run_instr(7'h6F, 1'b0, 0, "jal", n, pcw, regw, memw, ill);
        checks++;
        if (n !== 4 || pcw !== 2 || regw !== 1) begin
            errors++;
            $display("FAIL jal: got n=%0d pcw=%0d regw=%0d want 4 2 1", n, pcw, regw);
        end
    endtask

    task automatic test_illegal();
        int n, pcw, regw, memw, ill;
        run_instr(7'h7F, 1'b1, 0, "illegal", n, pcw, regw, memw, ill);
        checks++;
        if (n !== 2 || ill !== 1 || pcw !== 1 || regw !== 0 || memw !== 0) begin
            errors++;
            $display("FAIL illegal: got n=%0d ill=%0d pcw=%0d regw=%0d memw=%0d want 2 1 1 0 0",
                     n, ill, pcw, regw, memw);
        end
    endtask

    task automatic test_random();
        logic [6:0] o = 7'h03;
        for (int i = 0; i < 400; i++) begin
            if (ms == 0) o = ops[$urandom_range(0, 7)];
            cycle(o, 1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_r_jal();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
